// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM encodings, register offsets and default source count for irq_ctrl
package irq_pkg;
  localparam int NSRC_DEF = 6;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;
  localparam logic [1:0] R_PEND    = 2'd0;
  localparam logic [1:0] R_MASK    = 2'd1;
  localparam logic [1:0] R_STATUS  = 2'd2;
  localparam logic [1:0] R_EOI     = 2'd3;
endpackage

// File: rtl/irq_prio_sel.sv
// irq_prio_sel: picks the first set bit of vec_i searching upward (with wrap) from start_i
module irq_prio_sel
  import irq_pkg::*;
#(
  parameter int N = NSRC_DEF
) (
  input  logic [N-1:0] vec_i,
  input  logic [2:0]   start_i,
  output logic         valid_o,
  output logic [2:0]   idx_o
);
  logic [3:0] s;
  // Scan offsets from farthest to nearest so the nearest candidate is written last
  always_comb begin
    valid_o = |vec_i;
    idx_o = '0;
    s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, start_i} + 4'(k);
      s = s >= 4'(N) ? s - 4'(N) : s;
      if (vec_i[s[2:0]]) idx_o = s[2:0];
    end
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched interrupt controller with mask, W1C pending, EOI handshake; IRQ_CTRL_ROTATE_EN enables round-robin priority
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC = NSRC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic            ack,
  output logic            irq,
  output logic [2:0]      irq_id
);
  logic [NSRC-1:0] src_q, pend_q, pend_d, mask_q, mask_d, rise, w1c, id_oh;
  logic [1:0] state_q, state_d;
  logic [2:0] irq_id_q, irq_id_d, win, start;
  logic irq_q, rst_q, win_v, cur_ok, acked, eoi, unused_w;
  assign unused_w = ^wdata[31:NSRC];
  irq_prio_sel #(.N(NSRC)) u_sel (
    .vec_i  (pend_q & mask_q),
    .start_i(start),
    .valid_o(win_v),
    .idx_o  (win)
  );
`ifdef IRQ_CTRL_ROTATE_EN
  logic [2:0] ptr_q;
  // Round-robin pointer: search resumes just past the last acknowledged source
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else if (acked) ptr_q <= irq_id_q == 3'(NSRC - 1) ? 3'd0 : irq_id_q + 3'd1;
  end
  assign start = ptr_q;
`else
  assign start = 3'd0;
`endif
  // Next-state: edges set PEND after software/ack clears so a set always wins
  always_comb begin
    rise = src & ~src_q & {NSRC{~rst_q}};
    w1c = (we && addr == R_PEND) ? wdata[NSRC-1:0] : '0;
    id_oh = {{(NSRC-1){1'b0}}, 1'b1} << irq_id_q;
    cur_ok = pend_q[irq_id_q] & mask_q[irq_id_q];
    acked = state_q == S_REQ && cur_ok && ack;
    eoi = we && addr == R_EOI;
    pend_d = (pend_q & ~w1c & ~(acked ? id_oh : '0)) | rise;
    mask_d = (we && addr == R_MASK) ? wdata[NSRC-1:0] : mask_q;
    state_d = state_q == S_IDLE    ? (win_v ? S_REQ : S_IDLE) :
              state_q == S_REQ     ? (!cur_ok ? S_IDLE : ack ? S_SERVICE : S_REQ) :
              state_q == S_SERVICE ? (eoi ? S_IDLE : S_SERVICE) : S_IDLE;
    irq_id_d = (state_q == S_IDLE && win_v) ? win : irq_id_q;
  end
  // State registers; rst_q hides the first post-reset cycle so a source held through reset is not seen as an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      state_q <= S_IDLE;
      irq_id_q <= '0;
      irq_q <= 1'b0;
      rst_q <= 1'b1;
    end else begin
      src_q <= src;
      pend_q <= pend_d;
      mask_q <= mask_d;
      state_q <= state_d;
      irq_id_q <= irq_id_d;
      irq_q <= state_d == S_REQ;
      rst_q <= 1'b0;
    end
  end
  // Register read mux; unused bits and the write-only EOI read as zero
  always_comb begin
    rdata = addr == R_PEND   ? 32'(pend_q) :
            addr == R_MASK   ? 32'(mask_q) :
            addr == R_STATUS ? {27'b0, irq_id_q, state_q} : 32'b0;
  end
  assign irq = irq_q;
  assign irq_id = irq_id_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scenario tasks with a scoreboard queue of expected values for irq_ctrl
module tb_irq_ctrl;
  logic clk = 0, reset = 1, we = 0, ack = 0;
  logic [5:0] src = '0;
  logic [1:0] addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic irq;
  logic [2:0] irq_id;
  int n_pass = 0, n_tot = 0;
  int unsigned exp_q[$];
  int unsigned e;

  irq_ctrl #(.NSRC(6)) dut (
    .clk(clk), .reset(reset), .src(src), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .ack(ack), .irq(irq), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; src = '0; we = 0; ack = 0; addr = '0; wdata = '0;
    tick(); tick();
    reset = 0;
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1;
    tick();
    we = 0;
  endtask

  task automatic rd(input logic [1:0] a);
    addr = a;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0);
    rd(0); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL rst_pend got %h exp %h", rdata, e); else n_pass++;
    rd(1); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL rst_mask got %h exp %h", rdata, e); else n_pass++;
    rd(2); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL rst_status got %h exp %h", rdata, e); else n_pass++;
    rd(3); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL rst_eoi got %h exp %h", rdata, e); else n_pass++;
    e = exp_q.pop_front(); n_tot++; if (32'(irq) !== e) $display("FAIL rst_irq got %h exp %h", irq, e); else n_pass++;
    e = exp_q.pop_front(); n_tot++; if (32'(irq_id) !== e) $display("FAIL rst_id got %h exp %h", irq_id, e); else n_pass++;
    wr(2, 32'hFFFF_FFFF); exp_q.push_back(0);
    rd(2); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL status_ro got %h exp %h", rdata, e); else n_pass++;
    wr(1, 32'hFFFF_FFFF); exp_q.push_back(32'h3F); exp_q.push_back(0);
    rd(1); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL mask_rw got %h exp %h", rdata, e); else n_pass++;
    rd(3); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL eoi_rd got %h exp %h", rdata, e); else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    wr(1, 32'h3F);
    src = 6'h04; exp_q.push_back(32'h04); exp_q.push_back(0);
    tick(); src = '0;
    rd(0); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL basic_pend got %h exp %h", rdata, e); else n_pass++;
    e = exp_q.pop_front(); n_tot++; if (32'(irq) !== e) $display("FAIL basic_irq_early got %h exp %h", irq, e); else n_pass++;
    exp_q.push_back(1); exp_q.push_back(2);
    tick();
    e = exp_q.pop_front(); n_tot++; if (32'(irq) !== e) $display("FAIL basic_irq got %h exp %h", irq, e); else n_pass++;
    e = exp_q.pop_front(); n_tot++; if (32'(irq_id) !== e) $display("FAIL basic_id got %h exp %h", irq_id, e); else n_pass++;
    ack = 1; exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(32'h0A);
    tick(); ack = 0;
    e = exp_q.pop_front(); n_tot++; if (32'(irq) !== e) $display("FAIL ack_irq got %h exp %h", irq, e); else n_pass++;
    rd(0); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL ack_pend got %h exp %h", rdata, e); else n_pass++;
    rd(2); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL ack_status got %h exp %h", rdata, e); else n_pass++;
    wr(3, 32'h0); exp_q.push_back(32'h08);
    rd(2); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL eoi_status got %h exp %h", rdata, e); else n_pass++;
  endtask

  task automatic test_priority();
    do_reset();
    wr(1, 32'h3F);
    src = 6'h12; tick(); src = '0;
    exp_q.push_back(1);
    tick();
    e = exp_q.pop_front(); n_tot++; if (32'(irq_id) !== e) $display("FAIL prio_first got %h exp %h", irq_id, e); else n_pass++;
    ack = 1; tick(); ack = 0;
    exp_q.push_back(32'h10);
    rd(0); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL prio_pend got %h exp %h", rdata, e); else n_pass++;
    wr(3, 32'h5A);
    exp_q.push_back(1); exp_q.push_back(4);
    tick();
    e = exp_q.pop_front(); n_tot++; if (32'(irq) !== e) $display("FAIL prio_irq2 got %h exp %h", irq, e); else n_pass++;
    e = exp_q.pop_front(); n_tot++; if (32'(irq_id) !== e) $display("FAIL prio_second got %h exp %h", irq_id, e); else n_pass++;
  endtask

  task automatic test_rotate();
    do_reset();
    wr(1, 32'h3F);
    src = 6'h02; tick(); src = '0; tick();
    ack = 1; tick(); ack = 0;
    wr(3, 32'h0);
    src = 6'h09; tick(); src = '0;
`ifdef IRQ_CTRL_ROTATE_EN
    exp_q.push_back(3);
`else
    exp_q.push_back(0);
`endif
    exp_q.push_back(1);
    tick();
    e = exp_q.pop_front(); n_tot++; if (32'(irq_id) !== e) $display("FAIL rotate_id got %h exp %h", irq_id, e); else n_pass++;
    e = exp_q.pop_front(); n_tot++; if (32'(irq) !== e) $display("FAIL rotate_irq got %h exp %h", irq, e); else n_pass++;
  endtask

  task automatic test_masked();
    do_reset();
    src = 6'h20; tick(); src = '0;
    exp_q.push_back(32'h20); exp_q.push_back(0); exp_q.push_back(0);
    rd(0); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL mask_pend got %h exp %h", rdata, e); else n_pass++;
    tick();
    e = exp_q.pop_front(); n_tot++; if (32'(irq) !== e) $display("FAIL masked_irq1 got %h exp %h", irq, e); else n_pass++;
    tick();
    e = exp_q.pop_front(); n_tot++; if (32'(irq) !== e) $display("FAIL masked_irq2 got %h exp %h", irq, e); else n_pass++;
    wr(1, 32'h20);
    exp_q.push_back(1); exp_q.push_back(5);
    tick();
    e = exp_q.pop_front(); n_tot++; if (32'(irq) !== e) $display("FAIL unmask_irq got %h exp %h", irq, e); else n_pass++;
    e = exp_q.pop_front(); n_tot++; if (32'(irq_id) !== e) $display("FAIL unmask_id got %h exp %h", irq_id, e); else n_pass++;
  endtask

  task automatic test_set_priority();
    do_reset();
    wr(1, 32'h3F);
    src = 6'h04; tick(); src = '0; tick();
    tick();
    src = 6'h04;
    exp_q.push_back(32'h04); exp_q.push_back(1); exp_q.push_back(32'h09);
    wr(0, 32'h04);
    src = '0;
    rd(0); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL setwin_pend got %h exp %h", rdata, e); else n_pass++;
    tick();
    e = exp_q.pop_front(); n_tot++; if (32'(irq) !== e) $display("FAIL setwin_irq got %h exp %h", irq, e); else n_pass++;
    rd(2); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL setwin_status got %h exp %h", rdata, e); else n_pass++;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(32'h08);
    wr(0, 32'h04);
    rd(0); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL cancel_pend got %h exp %h", rdata, e); else n_pass++;
    tick();
    e = exp_q.pop_front(); n_tot++; if (32'(irq) !== e) $display("FAIL cancel_irq got %h exp %h", irq, e); else n_pass++;
    rd(2); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL cancel_status got %h exp %h", rdata, e); else n_pass++;
  endtask

  task automatic test_reset_service();
    do_reset();
    wr(1, 32'h3F);
    src = 6'h01; tick(); tick();
    ack = 1; tick(); ack = 0;
    exp_q.push_back(32'h02);
    rd(2); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL svc_state got %h exp %h", rdata, e); else n_pass++;
    reset = 1; tick(); tick(); reset = 0; tick(); tick();
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    rd(0); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL held_pend got %h exp %h", rdata, e); else n_pass++;
    e = exp_q.pop_front(); n_tot++; if (32'(irq) !== e) $display("FAIL held_irq got %h exp %h", irq, e); else n_pass++;
    rd(2); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL held_status got %h exp %h", rdata, e); else n_pass++;
    src = '0; tick();
    src = 6'h01; exp_q.push_back(32'h01);
    tick();
    rd(0); e = exp_q.pop_front(); n_tot++; if (rdata !== e) $display("FAIL rearm_pend got %h exp %h", rdata, e); else n_pass++;
    src = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_rotate();
    test_masked();
    test_set_priority();
    test_reset_service();
    n_tot++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
